rv2t_fetch_realign: RTL and testbench

- Instruction fetch realignment buffer. It sits directly upstream of the compressed-instruction expander.
- Issues word-aligned 32-bit reads to instruction memory and buffers the returned halfwords.
- Presents one instruction at a time, 16-bit or 32-bit, aligned to bits [15:0] of instr_o, with its PC, under a valid/ready handshake.
- Handles halfword-aligned branch/jump redirects and 32-bit instructions that straddle word boundaries.

---
 rtl/rv2t_fetch_realign.sv | 130 +++++++++++++
 tb/tb_rv2t_fetch_realign.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv2t_fetch_realign.sv
// Fetch realignment buffer: word-aligned reads in, one 16/32-bit instruction out at pc_o.
// Optional misaligned-target trap enabled by defining RV2T_FETCH_MISALIGN_TRAP_EN.
module rv2t_fetch_realign #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_re_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  misalign_o
);

    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

    state_t                  state, state_n;
    logic [15:0]             q [4];
    logic [15:0]             q_n [4];
    logic [2:0]              count, count_n;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_n, fetch_addr, fetch_n;
    logic                    skip_low, skip_n;
    logic                    trap_q, trap_n;
    logic                    valid_raw, pop_fire, pop_two, push, issue;

`ifdef RV2T_FETCH_MISALIGN_TRAP_EN
    // A redirect to an odd address traps until a redirect to an even address clears it.
    assign trap_n = jump_i ? jump_addr_i[0] : trap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) trap_q <= 1'b0;
        else       trap_q <= trap_n;
    end
`else
    assign trap_q = 1'b0;
    assign trap_n = 1'b0;
`endif

    assign misalign_o    = trap_q;
    assign valid_raw     = ((count != 3'd0) && (q[0][1:0] != 2'b11)) || (count >= 3'd2);
    assign instr_valid_o = valid_raw && !trap_q;
    assign instr_o       = {(count >= 3'd2) ? q[1] : 16'h0, q[0]};
    assign pc_o          = pc_q;
    assign pop_two       = (q[0][1:0] == 2'b11);
    assign pop_fire      = instr_valid_o && instr_ready_i && !jump_i;
    assign push          = (state == WAIT) && mem_ack_i && !jump_i;

    // Halfword queue update: the pop shifts first, then the returned halfwords append behind it.
    always_comb begin
        q_n     = q;
        count_n = count;
        if (pop_fire) begin
            if (pop_two) begin
                q_n[0]  = q[2];
                q_n[1]  = q[3];
                count_n = count - 3'd2;
            end else begin
                q_n[0]  = q[1];
                q_n[1]  = q[2];
                q_n[2]  = q[3];
                count_n = count - 3'd1;
            end
        end
        if (push) begin
            if (!skip_low) begin
                q_n[count_n[1:0]] = mem_rdata_i[15:0];
                count_n           = count_n + 3'd1;
            end
            q_n[count_n[1:0]] = mem_rdata_i[31:16];
            count_n           = count_n + 3'd1;
        end
        if (jump_i) count_n = 3'd0;
    end

    // Next fetch request is decided on the post-update queue level, so a refill or a
    // redirect can issue on the same edge that returns the FSM to IDLE.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        fetch_n = fetch_addr;
        skip_n  = skip_low;
        issue   = 1'b0;
        if ((state != IDLE) && mem_ack_i) state_n = IDLE;
        if (pop_fire) pc_n = pc_q + (pop_two ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2));
        if (push) begin
            fetch_n = fetch_addr + ADDR_WIDTH'(4);
            skip_n  = 1'b0;
        end
        if (jump_i) begin
            pc_n    = jump_addr_i & ~ADDR_WIDTH'(1);
            fetch_n = jump_addr_i & ~ADDR_WIDTH'(3);
            skip_n  = jump_addr_i[1];
            if ((state != IDLE) && !mem_ack_i) state_n = FLUSH;
        end
        if ((state_n == IDLE) && (count_n <= 3'd2) && !trap_n) begin
            issue   = 1'b1;
            state_n = WAIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 3'd0;
            for (int i = 0; i < 4; i++) q[i] <= 16'h0;
            pc_q       <= RESET_PC;
            fetch_addr <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
            skip_low   <= RESET_PC[1];
            mem_re_o   <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            q          <= q_n;
            pc_q       <= pc_n;
            fetch_addr <= fetch_n;
            skip_low   <= skip_n;
            mem_re_o   <= issue;
            if (issue) mem_addr_o <= fetch_n;
        end
    end

endmodule

// File: tb/tb_rv2t_fetch_realign.sv
// Directed self-checking bench for rv2t_fetch_realign with a behavioural memory responder.
module tb_rv2t_fetch_realign;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_re_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ack_i;
    logic [31:0]   mem_rdata_i;
    logic          jump_i;
    logic [AW-1:0] jump_addr_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [31:0]   instr_o;
    logic [AW-1:0] pc_o;
    logic          misalign_o;

    rv2t_fetch_realign #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_words [256];
    int          lat = 1;
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          overlap_cnt = 0;
    int          jc = 0;
    bit          r_pend = 1'b0;
    int          r_cnt = 0;
    logic [31:0] r_addr = 32'h0;

    logic [31:0] acc_pc[$];
    logic [31:0] acc_ins[$];
    int          acc_cyc[$];
    logic [31:0] iss_addr[$];
    int          iss_cyc[$];

    // Memory answers each strobe lat cycles later with the stored word.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (r_pend) begin
                if (r_cnt <= 1) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_words[r_addr[9:2]];
                    r_pend      = 1'b0;
                end else begin
                    r_cnt--;
                end
            end
            if (mem_re_o) begin
                if (r_pend) overlap_cnt++;
                r_pend = 1'b1;
                r_cnt  = lat;
                r_addr = mem_addr_o;
            end
        end
    end

    // Log every accepted instruction and every read strobe with its cycle number.
    always @(negedge clk) begin
        if (!reset && instr_valid_o && instr_ready_i && !jump_i) begin
            acc_pc.push_back(pc_o);
            acc_ins.push_back(instr_o);
            acc_cyc.push_back(cyc);
        end
        if (mem_re_o) begin
            iss_addr.push_back(mem_addr_o);
            iss_cyc.push_back(cyc);
        end
    end

    function automatic logic [15:0] hw(input int i);
        return {8'(8'h40 + i), 8'h01};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkAccept(input string tag, input int i, input logic [31:0] pc,
                               input logic [31:0] ins, input logic [31:0] mask);
        checkOutput({tag, "_present"}, 32'(acc_pc.size() > i), 32'h1);
        if (acc_pc.size() > i) begin
            checkOutput({tag, "_pc"}, acc_pc[i], pc);
            checkOutput({tag, "_instr"}, acc_ins[i] & mask, ins);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        acc_pc.delete();
        acc_ins.delete();
        acc_cyc.delete();
        iss_addr.delete();
        iss_cyc.delete();
    endtask

    // One-cycle redirect; logs restart from the cycle after the jump.
    task automatic applyStimulus(input logic [31:0] addr, input logic rdy);
        jump_i        = 1'b1;
        jump_addr_i   = addr;
        instr_ready_i = rdy;
        jc            = cyc;
        @(posedge clk);
        #1;
        jump_i = 1'b0;
        clearLogs();
    endtask

    task automatic settle();
        instr_ready_i = 1'b0;
        waitCycles(12);
    endtask

    initial begin
        reset         = 1'b1;
        jump_i        = 1'b0;
        jump_addr_i   = 32'h0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
        mem_words[0]   = 32'h00A00093;
        mem_words[1]   = 32'h00108113;
        mem_words[16]  = 32'h45050505;
        mem_words[32]  = 32'h00930505;
        mem_words[33]  = 32'h000000A0;
        mem_words[64]  = 32'h4505AAAA;
        mem_words[128] = 32'h00A00093;
        for (int k = 0; k < 4; k++) mem_words[192 + k] = {hw(2 * k + 1), hw(2 * k)};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_re", 32'(mem_re_o), 32'h0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
        checkOutput("rst_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("rst_instr", instr_o, 32'h0);
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'h0);
        reset = 1'b0;

        // 32-bit stream from the reset PC
        waitCycles(10);
        checkAccept("t1_i0", 0, 32'h0, 32'h00A00093, 32'hFFFFFFFF);
        checkAccept("t1_i1", 1, 32'h4, 32'h00108113, 32'hFFFFFFFF);
        checkOutput("t1_iss_count", 32'(iss_addr.size() >= 3), 32'h1);
        if (iss_addr.size() >= 3)
            for (int i = 0; i < 3; i++) checkOutput($sformatf("t1_iss%0d", i), iss_addr[i], 32'(4 * i));

        // two compressed instructions in one word, redirect from IDLE
        settle();
        applyStimulus(32'h40, 1'b1);
        waitCycles(8);
        checkAccept("t2_i0", 0, 32'h40, 32'h45050505, 32'hFFFFFFFF);
        checkAccept("t2_i1", 1, 32'h42, 32'h00004505, 32'hFFFFFFFF);
        checkAccept("t2_i2", 2, 32'h44, 32'h00000000, 32'h0000FFFF);
        if (acc_cyc.size() >= 2) begin
            checkOutput("t2_latency", 32'(acc_cyc[0] - jc), 32'd3);
            checkOutput("t2_back_to_back", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        end

        // 32-bit instruction straddling two words
        settle();
        applyStimulus(32'h80, 1'b1);
        waitCycles(8);
        checkAccept("t3_i0", 0, 32'h80, 32'h00930505, 32'hFFFFFFFF);
        checkAccept("t3_i1", 1, 32'h82, 32'h00A00093, 32'hFFFFFFFF);
        if (acc_cyc.size() >= 2) checkOutput("t3_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);

        // redirect to a halfword-aligned target drops the low half
        settle();
        applyStimulus(32'h102, 1'b1);
        waitCycles(6);
        checkOutput("t4_iss_count", 32'(iss_addr.size() >= 2), 32'h1);
        if (iss_addr.size() >= 2) begin
            checkOutput("t4_iss0", iss_addr[0], 32'h100);
            checkOutput("t4_iss1", iss_addr[1], 32'h104);
        end
        checkAccept("t4_i0", 0, 32'h102, 32'h00004505, 32'hFFFFFFFF);

        // redirect while a slow read is outstanding
        settle();
        lat = 3;
        applyStimulus(32'h180, 1'b1);
        waitCycles(1);
        applyStimulus(32'h200, 1'b1);
        checkOutput("t5_valid_after_redirect", 32'(instr_valid_o), 32'h0);
        waitCycles(10);
        lat = 1;
        checkOutput("t5_iss_present", 32'(iss_addr.size() >= 1), 32'h1);
        if (iss_addr.size() >= 1) begin
            checkOutput("t5_iss_addr", iss_addr[0], 32'h200);
            checkOutput("t5_iss_cycle", 32'(iss_cyc[0] - jc), 32'd3);
        end
        checkAccept("t5_i0", 0, 32'h200, 32'h00A00093, 32'hFFFFFFFF);
        if (acc_cyc.size() >= 1) checkOutput("t5_first_valid", 32'(acc_cyc[0] - jc), 32'd7);

        // backpressure: queue fills to four halfwords, then drains in order
        settle();
        applyStimulus(32'h300, 1'b0);
        waitCycles(10);
        checkOutput("t6_full_valid", 32'(instr_valid_o), 32'h1);
        checkOutput("t6_full_instr", instr_o, {hw(1), hw(0)});
        checkOutput("t6_full_pc", pc_o, 32'h300);
        checkOutput("t6_iss_count", 32'(iss_addr.size()), 32'd2);
        if (iss_addr.size() >= 2) checkOutput("t6_iss1", iss_addr[1], 32'h304);
        instr_ready_i = 1'b1;
        waitCycles(16);
        for (int i = 0; i < 8; i++)
            checkAccept($sformatf("t6_i%0d", i), i, 32'(32'h300 + 2 * i), 32'(hw(i)), 32'h0000FFFF);

        // odd redirect target
        settle();
        applyStimulus(32'h301, 1'b0);
        checkOutput("t7_pc", pc_o, 32'h300);
        checkOutput("t7_valid_after_redirect", 32'(instr_valid_o), 32'h0);
`ifdef RV2T_FETCH_MISALIGN_TRAP_EN
        checkOutput("t7_misalign", 32'(misalign_o), 32'h1);
        waitCycles(6);
        checkOutput("t7_valid_later", 32'(instr_valid_o), 32'h0);
`else
        checkOutput("t7_misalign", 32'(misalign_o), 32'h0);
        waitCycles(6);
        checkOutput("t7_valid_later", 32'(instr_valid_o), 32'h1);
`endif

        checkOutput("one_outstanding", 32'(overlap_cnt), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
